// File: rtl/pc_sequencer_pkg.sv
// ============================================================
// pc_sequencer_pkg : shared control encodings (NPC codes, FSM states)
// Revision 1.0
// ============================================================
`default_nettype none

package pc_sequencer_pkg;

   // Next-PC commands driven by the control decoder
   localparam logic [2:0] NPC_PLUS4  = 3'd0;
   localparam logic [2:0] NPC_BRANCH = 3'd1;
   localparam logic [2:0] NPC_JUMP   = 3'd2;
   localparam logic [2:0] NPC_JR     = 3'd3;
   localparam logic [2:0] NPC_EXCEPT = 3'd4;

   // Decoder opcode/funct fields that map onto the NPC commands
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] FUNCT_JR = 6'h08;

   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_3000;
   localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_4180;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_WAIT  = 2'd3
   } pc_state_e;

   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_npc.sv
// ============================================================
// npc_calc : combinational next-PC selection and exception detect
// Revision 1.0
// ============================================================
`default_nettype none

module npc_calc
   import pc_sequencer_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
   input  logic [31:0] pc,
   input  logic [2:0]  npc_op,
   input  logic [15:0] imm16,
   input  logic [25:0] jidx,
   input  logic [31:0] rs_val,
   output logic [31:0] npc,
   output logic        exc
);

   logic [31:0] pc_plus4;

   assign pc_plus4 = pc + 32'd4;

   always_comb begin
      npc = EXC_VECTOR;
      exc = 1'b0;
      case (npc_op)
         NPC_PLUS4:  npc = pc_plus4;
         NPC_BRANCH: npc = pc_plus4 + branch_offset(imm16);
         NPC_JUMP:   npc = {pc_plus4[31:28], jidx, 2'b00};
         NPC_JR: begin
            // A misaligned register target faults instead of jumping
            if (rs_val[1:0] == 2'b00) npc = rs_val;
            else                      exc = 1'b1;
         end
         default:    exc = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================
// pc_sequencer : fetch PC register, BOOT/RUN/FLUSH/WAIT control, EPC
// Revision 1.0
// ============================================================
`default_nettype none

module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  npc_op,
   input  logic [15:0] imm16,
   input  logic [25:0] jidx,
   input  logic [31:0] rs_val,
   input  logic        stall,
   input  logic        if_ready,
   output logic        imem_req,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        nop,
   output logic [31:0] epc,
   output logic [7:0]  exc_cnt
);

   pc_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] epc_q, epc_d;
   logic [7:0]  exc_cnt_q, exc_cnt_d;
   logic        imem_req_q, imem_req_d;
   logic        nop_q, nop_d;
   logic [31:0] npc;
   logic        exc;
   logic        advance;

   npc_calc #(
      .EXC_VECTOR (EXC_VECTOR)
   ) u_npc_calc (
      .pc     (pc_q),
      .npc_op (npc_op),
      .imm16  (imm16),
      .jidx   (jidx),
      .rs_val (rs_val),
      .npc    (npc),
      .exc    (exc)
   );

   assign pc_plus4 = pc_q + 32'd4;
   assign advance  = imem_req_q & if_ready & ~stall;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      epc_d     = epc_q;
      exc_cnt_d = exc_cnt_q;
      case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (advance) begin
               pc_d = npc;
               if (exc) begin
                  epc_d     = pc_q;
                  exc_cnt_d = (exc_cnt_q == 8'hFF) ? 8'hFF : exc_cnt_q + 8'd1;
                  state_d   = ST_FLUSH;
               end
            end else if (!stall && !if_ready) begin
               state_d = ST_WAIT;
            end
         end
         // The bubble slot ignores npc_op, so a second EXCEPT cannot land here
         ST_FLUSH, ST_WAIT: begin
            if (advance) begin
               pc_d    = pc_plus4;
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_BOOT;
      endcase
      imem_req_d = (state_d != ST_BOOT);
      nop_d      = (state_d != ST_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_VECTOR;
         epc_q      <= 32'd0;
         exc_cnt_q  <= 8'd0;
         imem_req_q <= 1'b0;
         nop_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         epc_q      <= epc_d;
         exc_cnt_q  <= exc_cnt_d;
         imem_req_q <= imem_req_d;
         nop_q      <= nop_d;
      end
   end

   assign pc       = pc_q;
   assign epc      = epc_q;
   assign exc_cnt  = exc_cnt_q;
   assign imem_req = imem_req_q;
   assign nop      = nop_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================
// tb_pc_sequencer : directed self-checking bench for pc_sequencer
// Revision 1.0
// ============================================================
`default_nettype none

module tb_pc_sequencer;
   import pc_sequencer_pkg::*;

   logic        clk;
   logic        rst;
   logic [2:0]  npc_op;
   logic [15:0] imm16;
   logic [25:0] jidx;
   logic [31:0] rs_val;
   logic        stall;
   logic        if_ready;
   logic        imem_req;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        nop;
   logic [31:0] epc;
   logic [7:0]  exc_cnt;

   int n_checks;
   int n_errors;

   pc_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .npc_op   (npc_op),
      .imm16    (imm16),
      .jidx     (jidx),
      .rs_val   (rs_val),
      .stall    (stall),
      .if_ready (if_ready),
      .imem_req (imem_req),
      .pc       (pc),
      .pc_plus4 (pc_plus4),
      .nop      (nop),
      .epc      (epc),
      .exc_cnt  (exc_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled one falling edge later
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      npc_op   = NPC_PLUS4;
      imm16    = 16'h0;
      jidx     = 26'h0;
      rs_val   = 32'h0;
      stall    = 1'b0;
      if_ready = 1'b1;

      @(negedge clk);
      tick();
      check("rst_pc", pc, 32'h0000_3000);
      check("rst_epc", epc, 32'h0);
      check("rst_cnt", {24'h0, exc_cnt}, 32'h0);
      check("rst_req", {31'h0, imem_req}, 32'h0);
      check("rst_nop", {31'h0, nop}, 32'h1);

      rst = 1'b0;
      check("boot_nop", {31'h0, nop}, 32'h1);
      tick();
      check("run_pc0", pc, 32'h0000_3000);
      check("run_nop", {31'h0, nop}, 32'h0);
      check("run_req", {31'h0, imem_req}, 32'h1);
      tick();
      check("run_pc1", pc, 32'h0000_3004);
      tick();
      check("run_pc2", pc, 32'h0000_3008);

      if_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("wait_pc", pc, 32'h0000_3008);
         check("wait_nop", {31'h0, nop}, 32'h1);
         check("wait_req", {31'h0, imem_req}, 32'h1);
      end
      if_ready = 1'b1;
      tick();
      check("wait_exit_pc", pc, 32'h0000_300C);
      check("wait_exit_nop", {31'h0, nop}, 32'h0);
      tick();
      check("pc_3010", pc, 32'h0000_3010);

      npc_op = NPC_BRANCH; imm16 = 16'hFFFC;
      tick();
      check("branch_back", pc, 32'h0000_3004);

      npc_op = NPC_JUMP; jidx = 26'h0000C10;
      tick();
      check("jump", pc, 32'h0000_3040);
      check("pc_plus4", pc_plus4, 32'h0000_3044);

      npc_op = NPC_JR; rs_val = 32'h0000_3020;
      tick();
      check("jr_ok", pc, 32'h0000_3020);
      check("jr_ok_cnt", {24'h0, exc_cnt}, 32'h0);

      rs_val = 32'h0000_3001;
      tick();
      check("jr_mis_pc", pc, 32'h0000_4180);
      check("jr_mis_epc", epc, 32'h0000_3020);
      check("jr_mis_cnt", {24'h0, exc_cnt}, 32'h1);
      check("flush_nop", {31'h0, nop}, 32'h1);

      npc_op = NPC_EXCEPT;
      tick();
      check("flush_pc", pc, 32'h0000_4184);
      check("flush_nop_off", {31'h0, nop}, 32'h0);
      check("flush_cnt", {24'h0, exc_cnt}, 32'h1);
      check("flush_epc", epc, 32'h0000_3020);

      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("stall_pc", pc, 32'h0000_4184);
         check("stall_epc", epc, 32'h0000_3020);
         check("stall_cnt", {24'h0, exc_cnt}, 32'h1);
      end
      stall = 1'b0;
      tick();
      check("stall_rel_pc", pc, 32'h0000_4180);
      check("stall_rel_epc", epc, 32'h0000_4184);
      check("stall_rel_cnt", {24'h0, exc_cnt}, 32'h2);
      npc_op = NPC_PLUS4;
      tick();
      check("stall_flush_pc", pc, 32'h0000_4184);
      check("stall_flush_cnt", {24'h0, exc_cnt}, 32'h2);

      npc_op = 3'b111;
      tick();
      check("undef_pc", pc, 32'h0000_4180);
      check("undef_epc", epc, 32'h0000_4184);
      check("undef_cnt", {24'h0, exc_cnt}, 32'h3);
      npc_op = NPC_PLUS4;
      tick();
      check("undef_flush_pc", pc, 32'h0000_4184);

      npc_op = NPC_JR; rs_val = 32'hF000_0010;
      tick();
      npc_op = NPC_JUMP; jidx = 26'h0000001;
      tick();
      check("jump_hi_nibble", pc, 32'hF000_0004);

      npc_op = NPC_JR; rs_val = 32'hFFFF_FFFC;
      tick();
      check("wrap_pc", pc, 32'hFFFF_FFFC);
      check("wrap_plus4", pc_plus4, 32'h0);
      npc_op = NPC_PLUS4;
      tick();
      check("wrap_to_zero", pc, 32'h0);

      for (int i = 0; i < 300; i++) begin
         npc_op = NPC_EXCEPT;
         tick();
         npc_op = NPC_PLUS4;
         tick();
      end
      check("sat_cnt", {24'h0, exc_cnt}, 32'hFF);

      npc_op = NPC_EXCEPT;
      tick();
      check("sat_hold_cnt", {24'h0, exc_cnt}, 32'hFF);
      check("sat_flush_pc", pc, 32'h0000_4180);
      check("sat_flush_nop", {31'h0, nop}, 32'h1);

      rst = 1'b1;
      tick();
      check("rst_flush_pc", pc, 32'h0000_3000);
      check("rst_flush_cnt", {24'h0, exc_cnt}, 32'h0);
      check("rst_flush_epc", epc, 32'h0);
      check("rst_flush_req", {31'h0, imem_req}, 32'h0);
      check("rst_flush_nop", {31'h0, nop}, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_3000: PC value loaded on reset.
REQ-002 Parameter EXC_VECTOR, default 32'h0000_4180: PC value loaded on an exception.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port npc_op, input, 3 bits: next-PC command from the control decoder, encoded with the shared NPC_* codes.
REQ-006 Port imm16, input, 16 bits: branch offset field of the current instruction.
REQ-007 Port jidx, input, 26 bits: jump index field of the current instruction.
REQ-008 Port rs_val, input, 32 bits: register-file rs read data, used as the JR target.
REQ-009 Port stall, input, 1 bit: hazard hold request; PC and state are frozen while it is high.
REQ-010 Port if_ready, input, 1 bit: instruction memory accepts the current fetch address.
REQ-011 Port imem_req, output, 1 bit: fetch request, valid together with pc.
REQ-012 Port pc, output, 32 bits: current fetch address.
REQ-013 Port pc_plus4, output, 32 bits: pc+4, combinational, used as the link value for jal.
REQ-014 Port nop, output, 1 bit: bubble indication to the control decoder.
REQ-015 Port epc, output, 32 bits: address of the instruction that faulted.
REQ-016 Port exc_cnt, output, 8 bits: saturating count of exceptions taken.

Function
REQ-017 The block SHALL implement states BOOT, RUN, FLUSH and WAIT.
REQ-018 The advance condition SHALL be imem_req & if_ready & !stall; pc, epc, exc_cnt and the state SHALL change only on advance, except for the BOOT->RUN transition.
REQ-019 BOOT: imem_req=0, nop=1; the block SHALL move to RUN one cycle after rst is released.
REQ-020 RUN: imem_req=1, nop=0; on advance the next PC SHALL be selected by npc_op as follows:
- PLUS4: pc+4.
- BRANCH: pc+4 + (sign-extended imm16 << 2).
- JUMP: {pc_plus4[31:28], jidx, 2'b00}.
- JR: rs_val.
- EXCEPT: EXC_VECTOR, with epc<=pc and the state going to FLUSH.
REQ-021 Any undefined npc_op code SHALL be handled exactly as EXCEPT.
REQ-022 JR with rs_val[1:0]!=0 SHALL be handled as EXCEPT: epc<=pc, pc<=EXC_VECTOR.
REQ-023 FLUSH: imem_req=1, nop=1 for exactly one advanced fetch, then the state SHALL return to RUN; npc_op SHALL be ignored in FLUSH and pc<=pc+4.
REQ-024 RUN with if_ready=0 and stall=0: the state SHALL go to WAIT with pc held; WAIT keeps imem_req=1 and nop=1, and the block SHALL return to RUN on the cycle if_ready=1.
REQ-025 stall=1 SHALL take priority over every npc_op, including EXCEPT: nothing is updated, and the exception SHALL be taken when the stall releases if npc_op still indicates it.
REQ-026 All address arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
REQ-027 exc_cnt SHALL increment once per exception taken and saturate at 8'hFF.
REQ-028 EXCEPT arriving while in FLUSH SHALL be ignored, so at most one exception is recorded per flush.

Reset
REQ-029 While rst is high, on each clock edge: pc=RESET_VECTOR, epc=0, exc_cnt=0, state=BOOT, imem_req=0, nop=1.
REQ-030 rst asserted mid-fetch or mid-FLUSH SHALL abandon the operation with no residual state.

Structure
REQ-031 The NPC_* codes, the state encoding, RESET_VECTOR and EXC_VECTOR SHALL live in the shared control-encoding definitions, alongside the decoder codes.
REQ-032 Next-address computation SHALL be a combinational sub-module npc_calc (pc, npc_op, imm16, jidx, rs_val -> npc, exc); the FSM and registers SHALL stay in pc_sequencer.

Verification
REQ-033 Reset, then RUN with npc_op=PLUS4 and if_ready=1 for 3 cycles -> pc sequence 3000, 3004, 3008, 300C; nop=1 only during the BOOT cycle.
REQ-034 pc=3010, BRANCH with imm16=16'hFFFC -> pc=3004; JUMP with jidx=26'h0000C10 -> pc=3040.
REQ-035 JR with rs_val=0000_3001 at pc=3020 -> pc=4180, epc=3020, exc_cnt=1, nop=1 for one fetch, then pc=4184.
REQ-036 EXCEPT with stall=1 for 2 cycles -> pc and epc unchanged; stall drops -> exception taken once and exc_cnt increments by exactly 1.
REQ-037 if_ready=0 for 3 cycles at pc=3008 -> WAIT, pc held at 3008, nop=1; if_ready=1 -> pc=300C.
REQ-038 300 forced exceptions -> exc_cnt=FF; rst asserted during FLUSH -> pc=3000 and exc_cnt=0 on the next edge.
